// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-master QSPI flash read arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit M_IF     = 1'b0;
    localparam bit M_LD     = 1'b1;
    localparam int STARVE_W = 4;

    function automatic logic [1:0] onehot_grant(input bit owner);
        return (owner == M_LD) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/flash_arb_if.sv
// Word read port: valid/ready handshake with byte address and 32-bit read data.
interface flash_arb_if #(
    parameter int AW = 24
);
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [31:0]   rdata;

    modport master (output valid, output addr, input ready, input rdata);
    modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/flash_arb_hitbuf.sv
// One-word read buffer for a single master, filled from flash and dropped on invalidate.
module flash_arb_hitbuf #(
    parameter int AW     = 24,
    parameter int HIT_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fill,
    input  logic          clear,
    input  logic [AW-3:0] fill_word,
    input  logic [31:0]   fill_data,
    input  logic [AW-3:0] lookup_word,
    output logic          hit,
    output logic [31:0]   data
);

    logic          vld;
    logic [AW-3:0] word_q;
    logic [31:0]   data_q;

    // Invalidate beats a same-cycle fill so a word read across an invalidate is never kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld    <= 1'b0;
            word_q <= '0;
            data_q <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (fill) begin
            vld    <= 1'b1;
            word_q <= fill_word;
            data_q <= fill_data;
        end
    end

    assign hit  = (HIT_EN != 0) && vld && (lookup_word == word_q);
    assign data = data_q;

endmodule

// File: rtl/flash_arb.sv
// Shares one flash read port between instruction fetch (m0) and data load (m1),
// favouring m0 streaming while bounding how long an m1 miss can wait.
module flash_arb
    import flash_arb_pkg::*;
#(
    parameter int AW         = 24,
    parameter int STARVE_MAX = 4,
    parameter int HIT_EN     = 1
) (
    input  logic        clk,
    input  logic        reset,
    flash_arb_if.slave  m0,
    flash_arb_if.slave  m1,
    flash_arb_if.master mem,
    input  logic        inv,
    output logic [1:0]  grant
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  last_grant;
    logic [AW-3:0]         last_word;
    logic                  last_vld;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  drop_fill;
    logic                  mem_valid_q;
    logic [AW-1:0]         mem_addr_q;
    logic [1:0]            grant_q;
    logic [31:0]           rdata0_q;
    logic [31:0]           rdata1_q;

    logic                  hb_hit0;
    logic                  hb_hit1;
    logic [31:0]           hb_data0;
    logic [31:0]           hb_data1;
    logic                  hit0;
    logic                  hit1;
    logic                  seq0;
    logic                  sel;
    logic                  take_hit;
    logic                  take_miss;
    logic                  mem_done;
    logic [AW-3:0]         req_word;
    logic                  addr_lsb_unused;

    assign addr_lsb_unused = ^{m0.addr[1:0], m1.addr[1:0]};

    flash_arb_hitbuf #(.AW(AW), .HIT_EN(HIT_EN)) u_hitbuf0 (
        .clk         (clk),
        .reset       (reset),
        .fill        (mem_done && (owner == M_IF) && !drop_fill),
        .clear       (inv),
        .fill_word   (mem_addr_q[AW-1:2]),
        .fill_data   (mem.rdata),
        .lookup_word (m0.addr[AW-1:2]),
        .hit         (hb_hit0),
        .data        (hb_data0)
    );

    flash_arb_hitbuf #(.AW(AW), .HIT_EN(HIT_EN)) u_hitbuf1 (
        .clk         (clk),
        .reset       (reset),
        .fill        (mem_done && (owner == M_LD) && !drop_fill),
        .clear       (inv),
        .fill_word   (mem_addr_q[AW-1:2]),
        .fill_data   (mem.rdata),
        .lookup_word (m1.addr[AW-1:2]),
        .hit         (hb_hit1),
        .data        (hb_data1)
    );

    // An invalidate in the same cycle as a lookup turns the hit into a miss.
    assign hit0     = m0.valid && hb_hit0 && !inv;
    assign hit1     = m1.valid && hb_hit1 && !inv;
    assign seq0     = last_vld && !inv && (m0.addr[AW-1:2] == last_word + (AW-2)'(1));
    assign mem_done = (state == ST_BUSY) && mem.ready;
    assign req_word = (sel == M_LD) ? m1.addr[AW-1:2] : m0.addr[AW-1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sel       = M_IF;
        take_hit  = 1'b0;
        take_miss = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit0) begin
                    state_nxt = ST_RESP;
                    sel       = M_IF;
                    take_hit  = 1'b1;
                end else if (hit1) begin
                    state_nxt = ST_RESP;
                    sel       = M_LD;
                    take_hit  = 1'b1;
                end else if (m0.valid || m1.valid) begin
                    state_nxt = ST_BUSY;
                    take_miss = 1'b1;
                    if (m0.valid && m1.valid)
                        sel = (seq0 && (starve_cnt < STARVE_LIM)) ? M_IF : ~last_grant;
                    else
                        sel = m1.valid ? M_LD : M_IF;
                end
            end
            ST_BUSY: if (mem.ready) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m0.ready  = (state == ST_RESP) && (owner == M_IF);
        m1.ready  = (state == ST_RESP) && (owner == M_LD);
        m0.rdata  = rdata0_q;
        m1.rdata  = rdata1_q;
        mem.valid = mem_valid_q;
        mem.addr  = mem_addr_q;
        grant     = grant_q;
    end

    // Flash port request registers stay frozen for the whole BUSY phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= M_IF;
            last_grant  <= M_LD;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            grant_q     <= 2'b00;
        end else if (take_hit) begin
            owner <= sel;
        end else if (take_miss) begin
            owner       <= sel;
            last_grant  <= sel;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {req_word, 2'b00};
            grant_q     <= onehot_grant(sel);
        end else if (mem_done) begin
            mem_valid_q <= 1'b0;
            grant_q     <= 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (take_hit) begin
            if (sel == M_IF) rdata0_q <= hb_data0;
            else             rdata1_q <= hb_data1;
        end else if (mem_done) begin
            if (owner == M_IF) rdata0_q <= mem.rdata;
            else               rdata1_q <= mem.rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_word <= '0;
            last_vld  <= 1'b0;
            drop_fill <= 1'b0;
        end else begin
            if (mem_done) begin
                last_word <= mem_addr_q[AW-1:2];
                last_vld  <= !inv;
            end else if (inv) begin
                last_vld <= 1'b0;
            end
            if ((state == ST_BUSY) && inv) drop_fill <= 1'b1;
            else if (state == ST_RESP)     drop_fill <= 1'b0;
        end
    end

    // Counts m0 miss grants that jumped ahead of a waiting m1 miss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!m1.valid) begin
            starve_cnt <= '0;
        end else if (take_miss) begin
            if (sel == M_LD)                  starve_cnt <= '0;
            else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: doc/flash_arb.md
# flash_arb

Two-master read arbiter in front of the QSPI flash read controller (valid/ready/addr/rdata word port, 24-bit byte address, continuous-read mode). Shares the single flash port between the instruction-fetch master (m0) and the data-load master (m1). Holds a one-word hit buffer per master and prefers m0 sequential continuations, so the flash stays in cheap streaming mode, with a starvation bound for m1. Sits between the CPU bus split and the flash controller.

## Interface
- `AW`, 24: byte address width, matches the flash controller port.
- `STARVE_MAX`, 4: maximum consecutive m0 grants while m1 has a pending miss (1..15).
- `HIT_EN`, 1: 1 enables the per-master hit buffers; 0 makes every request a miss.

- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_valid` in 1 / `m0_ready` out 1 / `m0_addr` in AW / `m0_rdata` out 32: instruction-fetch master.
- `m1_valid` in 1 / `m1_ready` out 1 / `m1_addr` in AW / `m1_rdata` out 32: data-load master.
- `inv` in 1: single-cycle pulse that invalidates both hit buffers.
- `mem_valid` out 1 / `mem_ready` in 1 / `mem_addr` out AW / `mem_rdata` in 32: flash controller port.
- `grant` out 2: one-hot owner of the flash port; 00 when idle.

## Operation
- Master protocol:
  - A master raises `valid` with a word-aligned `addr` and holds both until `ready`.
  - `ready` is a 1-cycle pulse, and `rdata` is valid in that cycle.
  - `addr[1:0]` is ignored; `mem_addr[1:0]` is always 0.
- States:
  - IDLE: evaluate requests.
  - BUSY: `mem_valid`=1, `mem_addr` registered from the owning master.
  - RESP: 1 cycle; the owner's `ready`=1.
- IDLE priority, evaluated in order, first match wins:
  1. m0 hit: `m0_valid` && hit_vld0 && `m0_addr`==hit_addr0 → RESP(m0), no flash access.
  2. m1 hit: same check on m1 → RESP(m1).
  3. Miss arbitration → BUSY(owner):
     - m0 is a sequential continuation (`m0_addr`==last_mem_addr+4, last_vld=1) and starve_cnt<STARVE_MAX → m0.
     - Otherwise round-robin: the master not granted last wins; a sole requester always wins.
- BUSY → RESP on `mem_ready`=1:
  - Capture `mem_rdata` into the owner's `rdata`.
  - Set last_mem_addr, last_vld=1.
  - Fill the owner's hit buffer (addr, data, vld=1) unless drop_fill is set.
- RESP → IDLE unconditionally. The m1 starvation check runs again at that IDLE.
- starve_cnt (4 bits):
  - +1 on each m0 miss grant while `m1_valid` && m1 misses.
  - Cleared on any m1 grant or when `m1_valid`=0.
  - Saturates at STARVE_MAX.
- `inv`:
  - Clears hit_vld0/1 and last_vld in the same cycle.
  - If `inv` arrives in BUSY, drop_fill is set: the in-flight word is still returned to its master but is not cached. drop_fill clears on entering IDLE.
  - `inv` coinciding with a hit check in IDLE: the invalidate wins and the request is treated as a miss.
- Hit buffer writes: only through fills; no write path exists (read-only flash).

## Timing
- Reset values:
  - `m0_ready`=`m1_ready`=0, `m*_rdata`=0.
  - `mem_valid`=0, `mem_addr`=0, `grant`=00.
  - state=IDLE, hit_vld=0, last_vld=0, starve_cnt=0, drop_fill=0.
  - last_grant=m1, so m0 wins the first tie.
- Hit latency: `valid` seen in cycle N → `ready` in cycle N+1.
- Miss latency: `valid` seen in cycle N → `mem_valid` in cycle N+1 → `mem_ready` in cycle M → master `ready` in cycle M+1.
- `mem_valid`, `mem_addr` and `grant` are registered and stable for the whole of BUSY. `mem_valid` drops in RESP.
- `reset` asserted mid-BUSY:
  - All outputs go to reset values immediately, asynchronously.
  - The transfer is abandoned; no `ready` is issued.
  - The flash controller recovers through its own address-jump path.
- Both masters requesting with both hits: m0 is served this round, m1 on the next IDLE. Each hit costs 2 cycles (RESP + IDLE).

## Structure
- `flash_arb_pkg`: state enum (IDLE/BUSY/RESP), master index constants `M_IF`=0 and `M_LD`=1, `STARVE_W`=4.
- Sub-module `flash_arb_hitbuf`, instanced once per master:
  - Holds addr/data/vld.
  - Inputs: fill, clear, lookup addr.
  - Outputs: hit, data.
  - With `HIT_EN`=0, hit is tied to 0.
- Top: FSM, arbitration, starve counter, last_mem_addr register.

## Test plan
- Single m0 miss at 0x000100, `mem_ready` 10 cycles after `mem_valid` → `m0_ready` one cycle later with `m0_rdata`=`mem_rdata`. Repeat to 0x000100 → `ready` 1 cycle after `valid`, `mem_valid` stays 0.
- m0 streaming 0x000000, 0x000004, … while m1 continuously requests 0x001000 → m1 granted after exactly 4 m0 grants (STARVE_MAX=4); starve_cnt then returns to 0.
- Non-sequential simultaneous misses (m0 0x000200, m1 0x003000) → grants alternate m0, m1, m0, …
- `inv` pulse during BUSY for m1 0x002000 → m1 still receives the data. A re-request to 0x002000 is a miss (`mem_valid`=1).
- Assert `reset` for 1 cycle mid-BUSY → `mem_valid`=0 and `grant`=00 immediately, no master `ready`, hit buffers empty. The next m0 request is a miss.
- `HIT_EN`=0 → repeated m0 0x000100 always produces `mem_valid`=1.
